// File: rtl/btn_counter_pkg.sv
// rtl/btn_counter_pkg.sv - shared debounce state type and threshold helper
package btn_counter_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } db_state_t;

    // Short qualification window used by simulation builds
    localparam int SIM_THRESHOLD = 16;

    // Number of consecutive stable synchronized samples needed to accept a level
    function automatic int debounce_threshold(input int clk_freq, input int debounce_ms,
                                              input int sim);
        return (sim != 0) ? SIM_THRESHOLD : debounce_ms * clk_freq * 1000;
    endfunction

endpackage

// File: rtl/button_counter_debouncer.sv
// rtl/button_counter_debouncer.sv - synchronizer plus press-qualifying debounce FSM for one button
module button_debouncer
    import btn_counter_pkg::*;
#(
    parameter int THRESHOLD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_BITS = $clog2(THRESHOLD + 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(THRESHOLD - 1);

    logic                sync_meta;
    logic                sync_q;
    db_state_t           state;
    logic [CNT_BITS-1:0] cnt;

    // Two-flop synchronizer for the raw asynchronous button level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_q    <= sync_meta;
        end
    end

    // Debounce FSM; the sample that leaves IDLE/PRESSED is the first of the N stable ones
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_q) begin
                        state <= WAIT_PRESS;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_PRESS: begin
                    if (!sync_q) begin
                        state <= IDLE;
                    end else if (cnt >= CNT_LAST) begin
                        state <= PRESSED;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_q) begin
                        state <= WAIT_RELEASE;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_RELEASE: begin
                    if (sync_q) begin
                        state <= PRESSED;
                    end else if (cnt >= CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_counter.sv
// rtl/button_counter.sv - debounced up/down/clear counter; BTN_CNT_SATURATE_EN selects saturation instead of wrap
module button_counter
    import btn_counter_pkg::*;
#(
    parameter int CLK_FREQ    = 125,
    parameter int DEBOUNCE_MS = 10,
    parameter int SIM         = 1,
    parameter int MAX_COUNT   = 9999,
    parameter int DATA_BITS   = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid
);

    localparam int THRESHOLD = debounce_threshold(CLK_FREQ, DEBOUNCE_MS, SIM);
    localparam logic [DATA_BITS-1:0] MAX_VAL = DATA_BITS'(MAX_COUNT);
    localparam logic [DATA_BITS-1:0] ONE     = DATA_BITS'(1);

    logic press_up;
    logic press_down;
    logic press_clr;
    logic load_pending;

    button_debouncer #(.THRESHOLD(THRESHOLD)) u_db_up (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_up),
        .press (press_up)
    );

    button_debouncer #(.THRESHOLD(THRESHOLD)) u_db_down (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_down),
        .press (press_down)
    );

    button_debouncer #(.THRESHOLD(THRESHOLD)) u_db_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clr),
        .press (press_clr)
    );

    // Count update: clear wins, opposing up/down cancel, first post-reset cycle reloads 0
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            load_pending   <= 1'b1;
        end else begin
            load_pending   <= 1'b0;
            data_out_valid <= load_pending;
            if (press_clr) begin
                data_out       <= '0;
                data_out_valid <= 1'b1;
            end else if (press_up && !press_down) begin
                if (data_out == MAX_VAL) begin
`ifdef BTN_CNT_SATURATE_EN
                    data_out <= data_out;
`else
                    data_out       <= '0;
                    data_out_valid <= 1'b1;
`endif
                end else begin
                    data_out       <= data_out + ONE;
                    data_out_valid <= 1'b1;
                end
            end else if (press_down && !press_up) begin
                if (data_out == '0) begin
`ifdef BTN_CNT_SATURATE_EN
                    data_out <= data_out;
`else
                    data_out       <= MAX_VAL;
                    data_out_valid <= 1'b1;
`endif
                end else begin
                    data_out       <= data_out - ONE;
                    data_out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_counter.sv
// tb/tb_button_counter.sv - self-checking bench for button_counter (SIM=1, MAX_COUNT=9999)
module tb_button_counter;

    localparam int MAXC = 9999;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_up;
    logic        btn_down;
    logic        btn_clr;
    logic [13:0] data_out;
    logic        data_out_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_cnt = 0;
    int change_err = 0;
    logic [13:0] prev_out = '0;
    int model_cnt;

    typedef struct {
        bit up;
        bit down;
        bit clr;
        int exp_count;
        int exp_strobes;
    } vec_t;
    vec_t tbl[8];

    button_counter #(
        .CLK_FREQ(125), .DEBOUNCE_MS(10), .SIM(1), .MAX_COUNT(9999), .DATA_BITS(14)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_clr        (btn_clr),
        .data_out       (data_out),
        .data_out_valid (data_out_valid)
    );

    always #5 clk = ~clk;

    // Count strobes and catch any output change that arrives without one
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (data_out_valid) strobe_cnt++;
            if (data_out != prev_out && !data_out_valid) change_err++;
        end
        prev_out = data_out;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_btn(input bit u, input bit d, input bit c);
        btn_up   = u;
        btn_down = d;
        btn_clr  = c;
    endtask

    // Short glitches on the chosen buttons, each too brief to qualify
    task automatic bounce(input bit u, input bit d, input bit c);
        int n;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            set_btn(u, d, c);
            repeat ($urandom_range(1, 12)) tick();
            set_btn(0, 0, 0);
            repeat ($urandom_range(1, 6)) tick();
        end
    endtask

    // One full press/release of a button set; returns strobes seen throughout
    task automatic press_op(input bit u, input bit d, input bit c, input int hold,
                            input bit do_bounce, output int strobes);
        int s0;
        s0 = strobe_cnt;
        if (do_bounce) bounce(u, d, c);
        set_btn(u, d, c);
        repeat (hold) tick();
        set_btn(0, 0, 0);
        repeat (24) tick();
        strobes = strobe_cnt - s0;
    endtask

    // Reference count rule written as modular arithmetic over 0..MAXC
    function automatic int model_next(input int c, input bit u, input bit d, input bit cl);
        if (cl) return 0;
        if (u && !d) begin
`ifdef BTN_CNT_SATURATE_EN
            return (c == MAXC) ? c : c + 1;
`else
            return (c + 1) % (MAXC + 1);
`endif
        end
        if (d && !u) begin
`ifdef BTN_CNT_SATURATE_EN
            return (c == 0) ? c : c - 1;
`else
            return (c + MAXC) % (MAXC + 1);
`endif
        end
        return c;
    endfunction

    initial begin
        int first_k;
        int seen;
        int st;
        int exp_next;
        bit u, d, c;

        tbl[0] = '{0, 0, 1, 0, 1};
        tbl[1] = '{0, 0, 1, 0, 1};
`ifdef BTN_CNT_SATURATE_EN
        tbl[2] = '{0, 1, 0, 0, 0};
        tbl[3] = '{1, 0, 0, 1, 1};
        tbl[4] = '{1, 0, 0, 2, 1};
        tbl[5] = '{1, 1, 0, 2, 0};
        tbl[6] = '{0, 1, 0, 1, 1};
`else
        tbl[2] = '{0, 1, 0, MAXC, 1};
        tbl[3] = '{1, 0, 0, 0, 1};
        tbl[4] = '{1, 0, 0, 1, 1};
        tbl[5] = '{1, 1, 0, 1, 0};
        tbl[6] = '{0, 1, 0, 0, 1};
`endif
        tbl[7] = '{1, 1, 1, 0, 1};

        reset = 1'b1;
        set_btn(0, 0, 0);
        repeat (4) tick();
        check("reset_data", data_out, 0);
        check("reset_valid", data_out_valid, 0);

        // Reset release: one reload strobe, then quiet
        reset = 1'b0;
        seen = 0; first_k = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (data_out_valid) begin
                seen++;
                if (first_k == 0) first_k = k;
            end
        end
        check("post_reset_strobes", seen, 1);
        check("post_reset_first", first_k, 1);
        check("post_reset_data", data_out, 0);

        // Clean held press: single strobe near 19 cycles, no repeat while held
        btn_up = 1'b1;
        seen = 0; first_k = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (data_out_valid) begin
                seen++;
                if (first_k == 0) first_k = k;
            end
        end
        check("hold_strobes", seen, 1);
        check_range("hold_latency", first_k, 18, 20);
        check("hold_data", data_out, 1);
        btn_up = 1'b0;
        repeat (24) tick();

        // Bounce every 5 cycles, then stable
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            btn_up = ((k / 5) % 2 == 0);
            tick();
            if (data_out_valid) seen++;
        end
        check("bounce_strobes", seen, 0);
        btn_up = 1'b1;
        seen = 0; first_k = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (data_out_valid) begin
                seen++;
                if (first_k == 0) first_k = k;
            end
        end
        check("settle_strobes", seen, 1);
        check_range("settle_latency", first_k, 18, 20);
        check("settle_data", data_out, 2);
        btn_up = 1'b0;
        repeat (24) tick();

        // Table of single operations
        for (int i = 0; i < 8; i++) begin
            press_op(tbl[i].up, tbl[i].down, tbl[i].clr, 20, 1'b0, st);
            check($sformatf("tbl%0d_data", i), data_out, tbl[i].exp_count);
            check($sformatf("tbl%0d_strobes", i), st, tbl[i].exp_strobes);
        end

        // Climb to 42, then all three buttons together
        for (int i = 0; i < 42; i++) press_op(1, 0, 0, 20, 1'b0, st);
        check("climb_data", data_out, 42);
        press_op(1, 1, 1, 20, 1'b0, st);
        check("all3_data", data_out, 0);
        check("all3_strobes", st, 1);

        // Reset in the middle of qualification with the button still held
        btn_up = 1'b1;
        repeat (12) tick();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        seen = 0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (data_out_valid) seen++;
        end
        check("midreset_early_strobes", seen, 1);
        check("midreset_early_data", data_out, 0);
        seen = 0;
        for (int k = 18; k <= 25; k++) begin
            tick();
            if (data_out_valid) seen++;
        end
        check("midreset_late_strobes", seen, 1);
        check("midreset_late_data", data_out, 1);
        btn_up = 1'b0;
        repeat (24) tick();

        // Randomized operations with glitches, checked against the model
        model_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            u = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 3) == 0);
            if (!u && !d && !c) u = 1'b1;
            exp_next = model_next(model_cnt, u, d, c);
            press_op(u, d, c, $urandom_range(20, 30), 1'b1, st);
            check($sformatf("rnd%0d_data", i), data_out, exp_next);
            check($sformatf("rnd%0d_strobes", i), st,
                  (c || exp_next != model_cnt) ? 1 : 0);
            model_cnt = exp_next;
        end

        check("silent_changes", change_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
